// File: rtl/trace_chk_pkg.sv
// Shared types and constants for the CPU trace line checker.
// Covers the parser state encoding, format codes, error bit positions and ASCII tokens.
package trace_chk_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TIME0,
        S_TIME,
        S_PC,
        S_SP1,
        S_GRF0,
        S_GRF,
        S_ADDR,
        S_SP2,
        S_EQ,
        S_SP3,
        S_DATA
    } state_e;

    typedef enum logic [1:0] {
        FMT_NONE = 2'd0,
        FMT_GRF  = 2'd1,
        FMT_MEM  = 2'd2
    } fmt_e;

    localparam int ERR_TIME = 0;
    localparam int ERR_PC   = 1;
    localparam int ERR_ADDR = 2;
    localparam int ERR_GRF  = 3;

    localparam logic [7:0] CH_CARET  = 8'h5e;  // '^'
    localparam logic [7:0] CH_AT     = 8'h40;  // '@'
    localparam logic [7:0] CH_COLON  = 8'h3a;  // ':'
    localparam logic [7:0] CH_SPACE  = 8'h20;  // ' '
    localparam logic [7:0] CH_DOLLAR = 8'h24;  // '$'
    localparam logic [7:0] CH_STAR   = 8'h2a;  // '*'
    localparam logic [7:0] CH_LT     = 8'h3c;  // '<'
    localparam logic [7:0] CH_EQ     = 8'h3d;  // '='
    localparam logic [7:0] CH_HASH   = 8'h23;  // '#'

    function automatic logic is_dec(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // Lowercase only: uppercase hex digits are deliberately rejected.
    function automatic logic is_hex(input logic [7:0] c);
        return is_dec(c) || ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    // Digit value of a dec/hex character; meaningless for other characters.
    function automatic logic [3:0] nibble(input logic [7:0] c);
        return is_dec(c) ? c[3:0] : (c[3:0] + 4'd9);
    endfunction

endpackage

// File: rtl/trace_chk_eval.sv
// Combinational semantic checks on a parsed trace line.
// Produces the 4-bit error code from time, pc, destination and the reference frequency.
module trace_chk_eval
    import trace_chk_pkg::*;
#(
    parameter int          FIELD_W = 16,
    parameter logic [31:0] GRF_MAX = 32'd31,
    parameter logic [31:0] PC_LO   = 32'h0000_3000,
    parameter logic [31:0] PC_HI   = 32'h0000_4fff,
    parameter logic [31:0] ADDR_LO = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI = 32'h0000_2fff
) (
    input  logic [1:0]         fmt,
    input  logic [FIELD_W-1:0] time_val,
    input  logic [31:0]        pc,
    input  logic [31:0]        addr,
    input  logic [FIELD_W-1:0] grf,
    input  logic [FIELD_W-1:0] freq,
    output logic [3:0]         err
);

    logic [FIELD_W-1:0] half;
    logic               time_ok;
    logic               pc_ok;
    logic               addr_ok;

    // Range tests use an unsigned offset from LO so that LO == 0 needs no special case;
    // this assumes LO <= HI.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        err     = '0;
        half    = freq >> 1;
        time_ok = (half != '0) && (time_val >= half)
                  && ((time_val & (half - FIELD_W'(1))) == '0);
        pc_ok   = (pc[1:0] == 2'b00) && ((pc - PC_LO) <= (PC_HI - PC_LO));
        addr_ok = (addr[1:0] == 2'b00) && ((addr - ADDR_LO) <= (ADDR_HI - ADDR_LO));

        err[ERR_TIME] = !time_ok;
        err[ERR_PC]   = !pc_ok;
        if (fmt == FMT_MEM) begin
            err[ERR_ADDR] = !addr_ok;
        end
        if (fmt == FMT_GRF) begin
            err[ERR_GRF] = 32'(grf) > GRF_MAX;
        end
    end

endmodule

// File: rtl/cpu_trace_checker.sv
// Streaming checker for CPU trace lines, one ASCII character per accepted cycle.
// Parses register/memory write lines and reports format, error code, fields and counts.
module cpu_trace_checker
    import trace_chk_pkg::*;
#(
    parameter int          TIME_DIGITS = 4,
    parameter int          GRF_DIGITS  = 4,
    parameter int          FIELD_W     = 16,
    parameter logic [31:0] GRF_MAX     = 32'd31,
    parameter logic [31:0] PC_LO       = 32'h0000_3000,
    parameter logic [31:0] PC_HI       = 32'h0000_4fff,
    parameter logic [31:0] ADDR_LO     = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI     = 32'h0000_2fff,
    parameter int          CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               char_valid,
    input  logic [7:0]         char,
    input  logic [FIELD_W-1:0] freq,
    output logic [1:0]         format_type,
    output logic [3:0]         error_code,
    output logic [FIELD_W-1:0] time_out,
    output logic [31:0]        pc_out,
    output logic [31:0]        dst_out,
    output logic [31:0]        data_out,
    output logic [CNT_W-1:0]   line_cnt,
    output logic [CNT_W-1:0]   err_cnt
);

    state_e             state;
    fmt_e               fmt;
    logic [7:0]         cnt;
    logic [FIELD_W-1:0] time_acc;
    logic [FIELD_W-1:0] grf_acc;
    logic [31:0]        pc_acc;
    logic [31:0]        addr_acc;
    logic [31:0]        data_acc;
    logic [3:0]         eval_err;
    logic [3:0]         nib;
    logic               dec;
    logic               hex;

    assign nib = nibble(char);
    assign dec = is_dec(char);
    assign hex = is_hex(char);

    trace_chk_eval #(
        .FIELD_W (FIELD_W),
        .GRF_MAX (GRF_MAX),
        .PC_LO   (PC_LO),
        .PC_HI   (PC_HI),
        .ADDR_LO (ADDR_LO),
        .ADDR_HI (ADDR_HI)
    ) u_eval (
        .fmt      (fmt),
        .time_val (time_acc),
        .pc       (pc_acc),
        .addr     (addr_acc),
        .grf      (grf_acc),
        .freq     (freq),
        .err      (eval_err)
    );

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            fmt         <= FMT_NONE;
            cnt         <= '0;
            time_acc    <= '0;
            grf_acc     <= '0;
            pc_acc      <= '0;
            addr_acc    <= '0;
            data_acc    <= '0;
            format_type <= FMT_NONE;
            error_code  <= '0;
            time_out    <= '0;
            pc_out      <= '0;
            dst_out     <= '0;
            data_out    <= '0;
            line_cnt    <= '0;
            err_cnt     <= '0;
        end else begin
            // The result pulse lasts one cycle whether or not a character arrives.
            format_type <= FMT_NONE;
            error_code  <= '0;

            if (char_valid) begin
                if (char == CH_CARET) begin
                    state <= S_TIME0;
                end else begin
                    // Anything not explicitly accepted below drops the line.
                    state <= S_IDLE;
                    unique case (state)
                        S_IDLE: ;
                        S_TIME0: begin
                            if (dec) begin
                                time_acc <= FIELD_W'(nib);
                                cnt      <= 8'd1;
                                state    <= S_TIME;
                            end
                        end
                        S_TIME: begin
                            if (dec && (cnt < 8'(TIME_DIGITS))) begin
                                time_acc <= time_acc * FIELD_W'(10) + FIELD_W'(nib);
                                cnt      <= cnt + 8'd1;
                                state    <= S_TIME;
                            end else if (char == CH_AT) begin
                                pc_acc <= '0;
                                cnt    <= '0;
                                state  <= S_PC;
                            end
                        end
                        S_PC: begin
                            if (hex && (cnt < 8'd8)) begin
                                pc_acc <= {pc_acc[27:0], nib};
                                cnt    <= cnt + 8'd1;
                                state  <= S_PC;
                            end else if ((char == CH_COLON) && (cnt == 8'd8)) begin
                                state <= S_SP1;
                            end
                        end
                        S_SP1: begin
                            if (char == CH_SPACE) begin
                                state <= S_SP1;
                            end else if (char == CH_DOLLAR) begin
                                fmt   <= FMT_GRF;
                                state <= S_GRF0;
                            end else if (char == CH_STAR) begin
                                fmt      <= FMT_MEM;
                                addr_acc <= '0;
                                cnt      <= '0;
                                state    <= S_ADDR;
                            end
                        end
                        S_GRF0: begin
                            if (dec) begin
                                grf_acc <= FIELD_W'(nib);
                                cnt     <= 8'd1;
                                state   <= S_GRF;
                            end
                        end
                        S_GRF: begin
                            if (dec && (cnt < 8'(GRF_DIGITS))) begin
                                grf_acc <= grf_acc * FIELD_W'(10) + FIELD_W'(nib);
                                cnt     <= cnt + 8'd1;
                                state   <= S_GRF;
                            end else if (char == CH_SPACE) begin
                                state <= S_SP2;
                            end else if (char == CH_LT) begin
                                state <= S_EQ;
                            end
                        end
                        S_ADDR: begin
                            if (hex && (cnt < 8'd8)) begin
                                addr_acc <= {addr_acc[27:0], nib};
                                cnt      <= cnt + 8'd1;
                                state    <= S_ADDR;
                            end else if ((char == CH_SPACE) && (cnt == 8'd8)) begin
                                state <= S_SP2;
                            end else if ((char == CH_LT) && (cnt == 8'd8)) begin
                                state <= S_EQ;
                            end
                        end
                        S_SP2: begin
                            if (char == CH_SPACE) begin
                                state <= S_SP2;
                            end else if (char == CH_LT) begin
                                state <= S_EQ;
                            end
                        end
                        S_EQ: begin
                            if (char == CH_EQ) begin
                                state <= S_SP3;
                            end
                        end
                        S_SP3: begin
                            if (char == CH_SPACE) begin
                                state <= S_SP3;
                            end else if (hex) begin
                                data_acc <= {28'd0, nib};
                                cnt      <= 8'd1;
                                state    <= S_DATA;
                            end
                        end
                        S_DATA: begin
                            if (hex && (cnt < 8'd8)) begin
                                data_acc <= {data_acc[27:0], nib};
                                cnt      <= cnt + 8'd1;
                                state    <= S_DATA;
                            end else if ((char == CH_HASH) && (cnt == 8'd8)) begin
                                format_type <= fmt;
                                error_code  <= eval_err;
                                time_out    <= time_acc;
                                pc_out      <= pc_acc;
                                dst_out     <= (fmt == FMT_GRF) ? 32'(grf_acc) : addr_acc;
                                data_out    <= data_acc;
                                if (line_cnt != '1) begin
                                    line_cnt <= line_cnt + CNT_W'(1);
                                end
                                if ((eval_err != 4'd0) && (err_cnt != '1)) begin
                                    err_cnt <= err_cnt + CNT_W'(1);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Scoreboard bench for cpu_trace_checker: a grammar-level reference model predicts each
// good line; a monitor pops predictions whenever the DUT pulses format_type.
module tb_cpu_trace_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char = 8'h00;
    logic [15:0] freq = 16'd0;

    logic [1:0]  format_type, s_format_type;
    logic [3:0]  error_code, s_error_code;
    logic [15:0] time_out, s_time_out;
    logic [31:0] pc_out, dst_out, data_out, s_pc_out, s_dst_out, s_data_out;
    logic [15:0] line_cnt, err_cnt;
    logic [1:0]  s_line_cnt, s_err_cnt;

    cpu_trace_checker dut (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char(char), .freq(freq),
        .format_type(format_type), .error_code(error_code), .time_out(time_out),
        .pc_out(pc_out), .dst_out(dst_out), .data_out(data_out),
        .line_cnt(line_cnt), .err_cnt(err_cnt)
    );

    cpu_trace_checker #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char(char), .freq(freq),
        .format_type(s_format_type), .error_code(s_error_code), .time_out(s_time_out),
        .pc_out(s_pc_out), .dst_out(s_dst_out), .data_out(s_data_out),
        .line_cnt(s_line_cnt), .err_cnt(s_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [3:0]  err;
        logic [15:0] tim;
        logic [31:0] pc;
        logic [31:0] dst;
        logic [31:0] data;
        longint      lc;
        longint      ec;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     n_cmp = 0;
    int     n_bad = 0;
    longint m_lines = 0;
    longint m_errs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (grammar over the text of a line) ----------------
    function automatic byte ch(string s, int p);
        return (p < s.len()) ? s[p] : 8'h00;
    endfunction

    // kind 0: decimal, 1: lowercase hex, 2: space
    function automatic bit in_cls(byte c, int kind);
        case (kind)
            0:       return (c >= "0" && c <= "9");
            1:       return (c >= "0" && c <= "9") || (c >= "a" && c <= "f");
            default: return (c == " ");
        endcase
    endfunction

    function automatic int run(string s, int p, int kind);
        int n = 0;
        while (in_cls(ch(s, p + n), kind)) n++;
        return n;
    endfunction

    function automatic longint unsigned val(string s, int p, int n, int base);
        longint unsigned v = 0;
        for (int i = 0; i < n; i++) begin
            byte c = s[p + i];
            v = v * base + ((c <= "9") ? (c - "0") : (c - "a" + 10));
        end
        return v;
    endfunction

    // Parses the text following a '^'; returns 1 for a complete well-formed line.
    function automatic bit parse_seg(string s, longint unsigned fr, output exp_t e);
        int p = 0;
        int n;
        bit mem;
        longint unsigned tim, pcv, dstv, datv, h;
        e = '{fmt: 0, err: 0, tim: 0, pc: 0, dst: 0, data: 0, lc: 0, ec: 0};
        n = run(s, p, 0);
        if (n < 1 || n > 4) return 0;
        tim = val(s, p, n, 10) % 65536; p += n;
        if (ch(s, p) != "@") return 0;
        p++;
        n = run(s, p, 1);
        if (n != 8) return 0;
        pcv = val(s, p, 8, 16); p += 8;
        if (ch(s, p) != ":") return 0;
        p++;
        p += run(s, p, 2);
        if (ch(s, p) == "$") mem = 0;
        else if (ch(s, p) == "*") mem = 1;
        else return 0;
        p++;
        n = run(s, p, mem ? 1 : 0);
        if (mem ? (n != 8) : (n < 1 || n > 4)) return 0;
        dstv = val(s, p, n, mem ? 16 : 10); p += n;
        p += run(s, p, 2);
        if (ch(s, p) != "<") return 0;
        p++;
        if (ch(s, p) != "=") return 0;
        p++;
        p += run(s, p, 2);
        n = run(s, p, 1);
        if (n != 8) return 0;
        datv = val(s, p, 8, 16); p += 8;
        if (ch(s, p) != "#") return 0;

        h = fr / 2;
        e.fmt    = mem ? 2'd2 : 2'd1;
        e.err[0] = !(h != 0 && tim >= h && (tim % h) == 0);
        e.err[1] = !((pcv % 4) == 0 && pcv >= 'h3000 && pcv <= 'h4fff);
        e.err[2] = mem && !((dstv % 4) == 0 && dstv <= 'h2fff);
        e.err[3] = !mem && (dstv > 31);
        e.tim  = 16'(tim);
        e.pc   = 32'(pcv);
        e.dst  = 32'(dstv);
        e.data = 32'(datv);
        return 1;
    endfunction

    function automatic void model_seg(string seg, longint unsigned fr);
        exp_t e;
        if (parse_seg(seg, fr, e)) begin
            m_lines++;
            if (e.err != 0) m_errs++;
            e.lc = (m_lines > 65535) ? 65535 : m_lines;
            e.ec = (m_errs > 65535) ? 65535 : m_errs;
            exp_q.push_back(e);
        end
    endfunction

    // Every '^' starts a fresh candidate line; text before the first '^' is ignored.
    function automatic void model_stream(string s, longint unsigned fr);
        int start = -1;
        for (int i = 0; i <= s.len(); i++) begin
            if (i == s.len() || s[i] == "^") begin
                if (start >= 0) model_seg(s.substr(start + 1, i - 1), fr);
                start = i;
            end
        end
    endfunction

    // ---------------- stimulus ----------------
    task automatic send_str(input string s, input int gmin, input int gmax);
        for (int i = 0; i < s.len(); i++) begin
            int g;
            g = $urandom_range(gmax, gmin);
            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                char_valid = 1'b0;
                char = 8'($urandom);
            end
            @(negedge clk);
            char_valid = 1'b1;
            char = s[i];
        end
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic run_line(input string s, input int gmin, input int gmax);
        model_stream(s, freq);
        send_str(s, gmin, gmax);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic string spaces(int n);
        string s = "";
        for (int i = 0; i < n; i++) s = {s, " "};
        return s;
    endfunction

    function automatic string gen_line();
        string s = "^";
        string junk = "Ax9:# Z<";
        int nd, r, pos;
        logic [31:0] pcv, a;
        nd = ($urandom_range(9, 0) == 0) ? 5 : $urandom_range(4, 1);
        for (int i = 0; i < nd; i++) s = $sformatf("%s%0d", s, $urandom_range(9, 0));
        r = $urandom_range(3, 0);
        pcv = (r == 0) ? $urandom : (32'h3000 + ($urandom_range(32'h7ff, 0) << 2));
        if (r == 1) pcv[1:0] = 2'($urandom_range(3, 1));
        s = $sformatf("%s@%08x:%s", s, pcv, spaces($urandom_range(2, 0)));
        if ($urandom_range(1, 0) == 1) begin
            a = ($urandom_range(3, 0) == 0) ? $urandom : ($urandom_range(32'hbff, 0) << 2);
            s = $sformatf("%s*%08x", s, a);
        end else if ($urandom_range(9, 0) == 0) begin
            s = $sformatf("%s$%0d", s, $urandom_range(99999, 10000));
        end else begin
            s = $sformatf("%s$%0d", s, $urandom_range(40, 0));
        end
        s = $sformatf("%s%s<=%s%08x#", s, spaces($urandom_range(2, 0)),
                      spaces($urandom_range(2, 0)), $urandom);
        if ($urandom_range(7, 0) == 0) begin
            pos = $urandom_range(s.len() - 1, 1);
            s[pos] = junk[$urandom_range(junk.len() - 1, 0)];
        end
        return s;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (format_type != 2'd0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 64'(format_type), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("format_type", 64'(format_type), 64'(mon_e.fmt));
                    check("error_code", 64'(error_code), 64'(mon_e.err));
                    check("time_out", 64'(time_out), 64'(mon_e.tim));
                    check("pc_out", 64'(pc_out), 64'(mon_e.pc));
                    check("dst_out", 64'(dst_out), 64'(mon_e.dst));
                    check("data_out", 64'(data_out), 64'(mon_e.data));
                    check("line_cnt", 64'(line_cnt), 64'(mon_e.lc));
                    check("err_cnt", 64'(err_cnt), 64'(mon_e.ec));
                end
            end else if (reset) begin
                check("idle_error_code", 64'(error_code), 64'd0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence, then random ----------------
    initial begin
        #12;
        check("rst_format_type", 64'(format_type), 64'd0);
        check("rst_error_code", 64'(error_code), 64'd0);
        check("rst_time_out", 64'(time_out), 64'd0);
        check("rst_pc_out", 64'(pc_out), 64'd0);
        check("rst_dst_out", 64'(dst_out), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_line_cnt", 64'(line_cnt), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        freq = 16'd4;
        run_line("^10@00003000: $1 <= 0000000a#", 0, 0);
        idle(2);
        check("grf_dst_held", 64'(dst_out), 64'd1);
        check("grf_data_held", 64'(data_out), 64'h0000000a);
        check("grf_line_cnt", 64'(line_cnt), 64'd1);

        run_line("^11@00003002:*00003000<=00000001#", 0, 0);
        idle(2);
        check("mem_err_cnt", 64'(err_cnt), 64'd1);

        run_line("^0@00004ffc: $32<= 12345678#", 0, 0);
        idle(2);
        check("pc_hi_held", 64'(pc_out), 64'h00004ffc);

        run_line("^12345@00003000:$0<=00000000#", 0, 0);
        run_line("^x^4@00003000:$0<=00000000#", 0, 0);
        run_line("^10@00003A00: $1 <= 0000000a#", 0, 0);
        run_line("^10@00003000: $1 <= 0000000a#", 3, 3);
        idle(4);

        // Reset in the middle of a line discards it and clears everything.
        send_str("^10@0000", 0, 0);
        @(negedge clk);
        reset = 1'b0;
        m_lines = 0;
        m_errs = 0;
        #1;
        check("midrst_format_type", 64'(format_type), 64'd0);
        check("midrst_pc_out", 64'(pc_out), 64'd0);
        check("midrst_dst_out", 64'(dst_out), 64'd0);
        check("midrst_data_out", 64'(data_out), 64'd0);
        check("midrst_line_cnt", 64'(line_cnt), 64'd0);
        check("midrst_err_cnt", 64'(err_cnt), 64'd0);
        check("midrst_sat_line_cnt", 64'(s_line_cnt), 64'd0);
        idle(2);
        reset = 1'b1;
        idle(2);

        run_line("^10@00003000: $1 <= 0000000a#", 0, 0);
        idle(2);
        check("post_rst_line_cnt", 64'(line_cnt), 64'd1);
        for (int i = 0; i < 4; i++) run_line("^10@00003000: $1 <= 0000000a#", 0, 1);
        idle(2);
        check("five_lines_cnt", 64'(line_cnt), 64'd5);
        check("sat_line_cnt_holds", 64'(s_line_cnt), 64'd3);

        freq = 16'd0;
        run_line("^8@00003000: $1 <= 00000000#", 0, 0);
        idle(2);

        for (int n = 0; n < 200; n++) begin
            freq = ($urandom_range(5, 0) == 0) ? 16'd0 : 16'(1 << $urandom_range(6, 0));
            run_line(gen_line(), 0, ($urandom_range(3, 0) == 0) ? 2 : 0);
        end
        idle(5);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("final_line_cnt", 64'(line_cnt), 64'((m_lines > 65535) ? 65535 : m_lines));
        check("final_err_cnt", 64'(err_cnt), 64'((m_errs > 65535) ? 65535 : m_errs));
        check("final_sat_line_cnt", 64'(s_line_cnt), 64'((m_lines > 3) ? 3 : m_lines));
        check("final_sat_err_cnt", 64'(s_err_cnt), 64'((m_errs > 3) ? 3 : m_errs));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
